// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers for the inverse cipher.
// The 128-bit state is packed with byte 0 = s(0,0) in bits [127:120]; byte k = row k%4, column k/4.
package aes_pkg;

    localparam int          NR       = 10;
    localparam int          NB       = 4;
    localparam int          RK_IDX_W = 4;
    localparam logic [7:0]  GF_POLY  = 8'h1b;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    // General GF(2^8) product; the column mixer only feeds it 09/0b/0d/0e.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Row r rotates right by r: out(r,c) takes in(r,(c-r) mod 4).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < NB; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (4 * c + row) -: 8] = s[127 - 8 * (4 * ((c - row) & 3) + row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_ctrl_inv_mix_columns.sv
// Combinational InvMixColumns: one matrix {0e,0b,0d,09} column unit per state column.
module inv_mix_column (
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);
    import aes_pkg::gf_mul;

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    assign col_o[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign col_o[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign col_o[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign col_o[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);

endmodule

module inv_mix_columns (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_mix_column u_col (
            .col_i (state_i[127 - 32 * c -: 32]),
            .col_o (state_o[127 - 32 * c -: 32])
        );
    end

endmodule

// File: rtl/inv_sub_bytes.sv
// 128-bit combinational inverse substitution: sixteen parallel inverse S-boxes.
// Each byte is un-affined and then inverted in GF(2^8); zero maps through the inverse to zero.
module inv_sub_bytes (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    import aes_pkg::gf_mul;

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] res;
        p   = a;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            res = gf_mul(res, p);
        end
        return res;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            t[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        end
        return gf_inv(t ^ 8'h05);
    endfunction

    for (genvar k = 0; k < 16; k++) begin : g_byte
        assign state_o[127 - 8 * k -: 8] = inv_sbox(state_i[127 - 8 * k -: 8]);
    end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 decryption controller: one block in 11 cycles through a single
// shared inverse-round datapath; round keys are fetched combinationally by index.
module aes_inv_cipher_ctrl #(
    parameter int NR       = 10,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [127:0]        ct_in,
    output logic                ready,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk_data,
    output logic [127:0]        pt_out,
    output logic                done
);
    import aes_pkg::state_e;
    import aes_pkg::IDLE;
    import aes_pkg::ROUND;
    import aes_pkg::FINAL;
    import aes_pkg::DONE;

    state_e              fsm_q, fsm_d;
    logic [RK_IDX_W-1:0] cnt_q, cnt_d;
    logic [127:0]        state_reg_q, state_reg_d;
    logic [127:0]        pt_q, pt_d;

    logic [127:0] isr, isb, ark, imc;

    // Shared round datapath; FINAL taps it before the column mix.
    assign isr = aes_pkg::inv_shift_rows(state_reg_q);

    inv_sub_bytes u_isb (
        .state_i (isr),
        .state_o (isb)
    );

    assign ark = isb ^ rk_data;

    inv_mix_columns u_imc (
        .state_i (ark),
        .state_o (imc)
    );

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        state_reg_d = state_reg_q;
        pt_d        = pt_q;
        rk_idx      = RK_IDX_W'(NR);
        ready       = 1'b0;
        done        = 1'b0;
        case (fsm_q)
            IDLE: begin
                ready  = 1'b1;
                rk_idx = RK_IDX_W'(NR);
                if (start) begin
                    state_reg_d = ct_in ^ rk_data;
                    cnt_d       = RK_IDX_W'(NR - 1);
                    fsm_d       = ROUND;
                end
            end
            ROUND: begin
                rk_idx      = cnt_q;
                state_reg_d = imc;
                cnt_d       = cnt_q - RK_IDX_W'(1);
                if (cnt_q == RK_IDX_W'(1)) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                rk_idx = '0;
                pt_d   = ark;
                fsm_d  = DONE;
            end
            DONE: begin
                done  = 1'b1;
                cnt_d = RK_IDX_W'(NR);
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            cnt_q       <= RK_IDX_W'(NR);
            state_reg_q <= '0;
            pt_q        <= '0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            state_reg_q <= state_reg_d;
            pt_q        <= pt_d;
        end
    end

    assign pt_out = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl with a behavioural AES-128 key-expansion store.
module tb_aes_inv_cipher_ctrl;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] ST0  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] CTZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] ct_in;
    logic         ready;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic [127:0] pt_out;
    logic         done;

    logic [127:0] rks [0:10];
    int total;
    int bad;

    aes_inv_cipher_ctrl #(.NR(10), .RK_IDX_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ct_in   (ct_in),
        .ready   (ready),
        .rk_idx  (rk_idx),
        .rk_data (rk_data),
        .pt_out  (pt_out),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rk_data = '0;
        if (rk_idx <= 4'd10) rk_data = rks[rk_idx];
    end

    function automatic logic [7:0] m_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = m_xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] s;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (m_mul(a, 8'(y)) == 8'h01) inv = 8'(y);
        end
        for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
        end
        return s ^ 8'h63;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])} ^ {rc, 24'h0};
                rc = m_xt(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rks[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        ct_in = CT1;
        tick();
        tick();
        start = 1'b0;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (pt_out !== 128'h0) begin bad++; $display("FAIL reset_pt: got %h want 0", pt_out); end
        total++; if (rk_idx !== 4'd10) begin bad++; $display("FAIL reset_rk_idx: got %0d want 10", rk_idx); end
        total++; if (dut.state_reg_q !== 128'h0) begin bad++; $display("FAIL reset_state: got %h want 0", dut.state_reg_q); end
        rst_n = 1'b1;
        tick();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", ready); end
    endtask

    task automatic test_fips();
        for (int i = 0; i < 20 && ready !== 1'b1; i++) tick();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL fips_idle_timeout: got %b want 1", ready); end
        ct_in = CT1;
        start = 1'b1;
        #1;
        total++; if (rk_idx !== 4'd10) begin bad++; $display("FAIL fips_rk_idx_T: got %0d want 10", rk_idx); end
        total++; if (rk_data !== RK10) begin bad++; $display("FAIL fips_rk10: got %h want %h", rk_data, RK10); end
        tick();
        start = 1'b0;
        ct_in = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        total++; if (dut.state_reg_q !== ST0) begin bad++; $display("FAIL fips_state0: got %h want %h", dut.state_reg_q, ST0); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL fips_busy: got %b want 0", ready); end
        for (int k = 9; k >= 0; k--) begin
            total++; if (rk_idx !== 4'(k)) begin bad++; $display("FAIL fips_rk_seq: got %0d want %0d", rk_idx, k); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL fips_early_done: got %b want 0 (rk %0d)", done, k); end
            tick();
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL fips_done: got %b want 1", done); end
        total++; if (pt_out !== PT1) begin bad++; $display("FAIL fips_pt: got %h want %h", pt_out, PT1); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL fips_done_width: got %b want 0", done); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL fips_ready_back: got %b want 1", ready); end
        total++; if (pt_out !== PT1) begin bad++; $display("FAIL fips_pt_hold: got %h want %h", pt_out, PT1); end
    endtask

    task automatic test_busy();
        ct_in = CT1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        ct_in = CTZ;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL busy_ready: got %b want 0", ready); end
        repeat (6) tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL busy_done: got %b want 1", done); end
        total++; if (pt_out !== PT1) begin bad++; $display("FAIL busy_pt: got %h want %h", pt_out, PT1); end
        tick();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL busy_ready_back: got %b want 1", ready); end
        for (int n = 12; n <= 16; n++) begin
            total++; if (done !== 1'b0) begin bad++; $display("FAIL busy_queued_done: got %b want 0 at T+%0d", done, n); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20 && ready !== 1'b1; i++) tick();
        ct_in = CT1;
        start = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            tick();
            total++; if (done !== (n == 11 || n == 23)) begin bad++; $display("FAIL b2b_done: got %b at T+%0d", done, n); end
            if (n == 11 || n == 23) begin
                total++; if (pt_out !== PT1) begin bad++; $display("FAIL b2b_pt: got %h want %h", pt_out, PT1); end
            end
            if (n == 12) begin
                total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_ready12: got %b want 1", ready); end
            end
            if (n == 23) start = 1'b0;
        end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_idle: got %b want 1", ready); end
    endtask

    task automatic test_reset_mid();
        ct_in = CT1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", done); end
        total++; if (pt_out !== 128'h0) begin bad++; $display("FAIL rstmid_pt: got %h want 0", pt_out); end
        total++; if (rk_idx !== 4'd10) begin bad++; $display("FAIL rstmid_rk_idx: got %0d want 10", rk_idx); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done7: got %b want 0", done); end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 9; n <= 18; n++) begin
            total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_early_done: got %b want 0 at T+%0d", done, n); end
            tick();
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rstmid_done19: got %b want 1", done); end
        total++; if (pt_out !== PT1) begin bad++; $display("FAIL rstmid_pt19: got %h want %h", pt_out, PT1); end
        tick();
    endtask

    task automatic test_all_zero();
        expand_key(128'h0);
        for (int i = 0; i < 20 && ready !== 1'b1; i++) tick();
        ct_in = CTZ;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        total++; if (rk_idx !== 4'd0) begin bad++; $display("FAIL zero_rk_idx_final: got %0d want 0", rk_idx); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_early_done: got %b want 0", done); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done); end
        total++; if (pt_out !== 128'h0) begin bad++; $display("FAIL zero_pt: got %h want 0", pt_out); end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        ct_in = '0;
        expand_key(KEY1);
        test_reset();
        test_fips();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        test_all_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
Name: aes_inv_cipher_ctrl

Overview:
- Iterative AES-128 decryption round controller. Sequences one ciphertext block through the inverse round datapath in 11 clock cycles:
  - initial AddRoundKey
  - 9 full inverse rounds
  - 1 final inverse round
- Instantiates the 128-bit combinational inverse S-box datapath once and reuses it every round.
- Sits between the SPI front-end (block and start handshake) and the key-expansion store, which supplies round keys by index.

Parameters:
- NR, 10, number of AES rounds (AES-128 only; other values unsupported).
- RK_IDX_W, 4, width of the round-key index bus.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request to decrypt ct_in; accepted only when ready=1.
- ct_in  input  128  ciphertext block, bit order [0:127]; byte 0 = bits [0:7] = AES state byte s(0,0).
- ready  output  1  controller idle, can accept start.
- rk_idx  output  RK_IDX_W  round-key index requested this cycle (0..10).
- rk_data  input  128  round key for rk_idx. Combinational read: must be valid in the same cycle, bit order [0:127].
- pt_out  output  128  plaintext result, held stable until the next accepted start.
- done  output  1  one-cycle pulse when pt_out becomes valid.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state -> IDLE; ready=1, done=0, pt_out=128'h0.
  - Internal state register = 0; round counter = NR.
  - Reset mid-operation abandons the block; no done is issued.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - rk_idx=NR.
  - On start=1: state_reg <= ct_in ^ rk_data; round counter <= NR-1; go to ROUND; ready drops to 0 the next cycle.
- ROUND:
  - rk_idx = round counter.
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk_data).
  - Counter decrements.
  - When counter==1, the update is performed and the FSM goes to FINAL.
  - Exactly 9 ROUND cycles, for rk indices 9 down to 1.
- FINAL:
  - rk_idx=0.
  - pt_out <= InvSubBytes(InvShiftRows(state_reg)) ^ rk_data.
  - Go to DONE.
- DONE:
  - done=1 for exactly this one cycle; ready=0.
  - Next state IDLE, with ready=1.
- Latency: start sampled at edge T -> done=1 and pt_out valid in cycle T+11. Next start is accepted at edge T+12 at the earliest, giving throughput of one block per 12 cycles.
- start while ready=0 is ignored (not queued); ct_in is only sampled on acceptance.
- InvShiftRows: row r is cyclically rotated right by r bytes. Byte k maps to row k%4, column k/4.
- InvMixColumns:
  - Per column, multiply by matrix {0e,0b,0d,09} over GF(2^8).
  - Reduction polynomial x^8+x^4+x^3+x+1 (0x11b).
  - All arithmetic is 8-bit XOR / xtime; no carries.
- The inverse S-box never outputs X for a legal byte; every 8-bit value maps.
- rk_idx is a pure function of FSM state and counter, with no glitch-dependent timing; the key store must not register it.
- pt_out changes only in FINAL; it is otherwise held, including through IDLE.

Decomposition:
- Shared package aes_pkg holds:
  - constants NR=10, NB=4, RK_IDX_W=4, GF_POLY=8'h1b
  - FSM state enum (IDLE, ROUND, FINAL, DONE)
  - functions xtime, gf_mul (by 09/0b/0d/0e) and inv_shift_rows
- One natural sub-module: inv_mix_columns, a 128-bit combinational block of 4 column instances.
- The inverse S-box is instantiated as the existing 128-bit inverse substitution block.

Test Plan:
- FIPS-197 C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f (bench key store models the expansion), ct_in=69c4e0d86a7b0430d8cdb78070b4c55a, start pulsed at T.
  - Required: rk_idx sequence 10,9,...,1,0 on cycles T..T+10; pt_out=00112233445566778899aabbccddeeff with done=1 exactly at T+11.
- Initial round key: in IDLE, rk_idx=10 and rk_data=13111d7fe3944a17f307a78b4d2b30c5 -> state_reg after T = 7ad5fda789ef4e272bca100b3d9ff59f.
- Busy rejection: second start with a different ct_in at T+4 -> ignored; result still 00112233...eeff at T+11; ready returns to 1 at T+12.
- Back-to-back: start held high continuously -> accepts at T and T+12; done pulses at T+11 and T+23; each done is one cycle wide.
- Reset mid-operation: rst_n=0 at T+5 -> next cycle ready=1, done=0, pt_out=0; no done follows. A fresh start at T+8 yields the correct result at T+19.
- All-zero inputs: key all 00 and ct_in=66e94bd4ef8a2c3b884cfa59ca342b2e -> pt_out=00000000000000000000000000000000.
